// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes and controller states.
// Used by alu_mc and alu_mc_muldiv.
package alu_mc_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative datapath: shift-add multiply and, when ALU_MC_DIV_EN is defined,
// restoring unsigned divide. One bit per step, WIDTH steps per operation.
module alu_mc_muldiv
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             step_i,
`ifdef ALU_MC_DIV_EN
    input  logic             div_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_MC_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
`endif

    // hi holds the partial product (multiply) or partial remainder (divide);
    // lo holds the multiplier bits still to consume or the growing quotient.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        hi_d    = mul_sum[WIDTH:1];
        lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_q) begin
            // A set top bit means the trial subtraction borrowed: restore.
            hi_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
`ifdef ALU_MC_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start_i) begin
            hi_q   <= '0;
            lo_q   <= a_i;
            opnd_q <= b_i;
            cnt_q  <= CNT_W'(WIDTH - 1);
`ifdef ALU_MC_DIV_EN
            div_q  <= div_i;
`endif
        end else if (step_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // The final step's values are handed out combinationally so the top
    // can register them on the same edge the iteration completes.
    assign done_o = step_i && (cnt_q == '0);
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides and registered outputs.
// Define ALU_MC_DIV_EN to build in the DIVU datapath; otherwise DIVU is illegal.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             dz,
    output logic             err,
    output state_e           dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);

    // Handshake: a transfer happens on any edge where valid && ready; the
    // producer holds its fields until then, and ready never depends on valid.
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d, err_q, err_d;
    logic             accept, iter_op, md_done;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [WIDTH-1:0] add_r, sub_r, sc_res, sc_hi;
    logic             add_ovf, sub_ovf, sc_ovf, sc_dz, sc_err;

    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    assign add_r   = a + b;
    assign sub_r   = a - b;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_MC_DIV_EN
    assign iter_op = (op == OP_MUL) || (op == OP_DIVU && b != '0);
`else
    assign iter_op = (op == OP_MUL);
`endif

    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_dz  = 1'b0;
        sc_err = 1'b0;
        case (op)
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_ADD: begin
                sc_res = add_r;
                sc_ovf = add_ovf;
            end
            OP_SUB: begin
                sc_res = sub_r;
                sc_ovf = sub_ovf;
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, sub_r[WIDTH-1] ^ sub_ovf};
            OP_NOR: sc_res = ~(a | b);
            OP_MUL: sc_res = '0;
`ifdef ALU_MC_DIV_EN
            // Only the divide-by-zero case takes the single-cycle path.
            OP_DIVU: begin
                sc_res = '1;
                sc_hi  = a;
                sc_dz  = 1'b1;
            end
`endif
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        err_d    = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (iter_op) begin
                        state_d = BUSY;
                    end else begin
                        state_d  = DONE;
                        result_d = sc_res;
                        hi_d     = sc_hi;
                        zero_d   = (sc_res == '0);
                        ovf_d    = sc_ovf;
                        dz_d     = sc_dz;
                        err_d    = sc_err;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d  = DONE;
                    result_d = md_lo;
                    hi_d     = md_hi;
                    zero_d   = (md_lo == '0);
                    ovf_d    = 1'b0;
                    dz_d     = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            err_q    <= err_d;
        end
    end

    alu_mc_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept && iter_op),
        .step_i  (state_q == BUSY),
`ifdef ALU_MC_DIV_EN
        .div_i   (op == OP_DIVU),
`endif
        .a_i     (a),
        .b_i     (b),
        .done_o  (md_done),
        .lo_o    (md_lo),
        .hi_o    (md_hi)
    );

    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus randomized ops against
// an arithmetic reference model. Follows ALU_MC_DIV_EN to pick DIVU behaviour.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int     W       = 16;
    localparam int     EW      = 2 * W + 4;
    localparam int     TIMEOUT = 100;
    localparam longint SMAX    = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN    = -(longint'(1) <<< (W - 1));

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b, result, hi;
    logic         zero, ovf, dz, err;
    state_e       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    int            lat_q[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .zero      (zero),
        .ovf       (ovf),
        .dz        (dz),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scoreboard helpers ----------------
    function automatic logic [EW-1:0] pk(input logic [W-1:0] r, input logic [W-1:0] h,
                                         input logic z, input logic v, input logic d,
                                         input logic e);
        return {r, h, z, v, d, e};
    endfunction

    function automatic logic [EW-1:0] obs_fields();
        return {result, hi, zero, ovf, dz, err};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model computed straight from the arithmetic definitions.
    function automatic logic [EW-1:0] ref_model(input logic [3:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y, output int lat);
        logic [W-1:0]   r, h;
        logic           v, d, e;
        longint         sx, sy, full;
        logic [2*W-1:0] p;
        r   = '0;
        h   = '0;
        v   = 1'b0;
        d   = 1'b0;
        e   = 1'b0;
        lat = 1;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        case (o)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin
                full = sx + sy;
                r    = W'(full);
                v    = (full > SMAX) || (full < SMIN);
            end
            4'b0110: begin
                full = sx - sy;
                r    = W'(full);
                v    = (full > SMAX) || (full < SMIN);
            end
            4'b0111: r = (sx < sy) ? W'(1) : '0;
            4'b1100: r = ~(x | y);
            4'b1000: begin
                p   = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                r   = p[W-1:0];
                h   = p[2*W-1:W];
                lat = W + 1;
            end
`ifdef ALU_MC_DIV_EN
            4'b1001: begin
                if (y == '0) begin
                    r = '1;
                    h = x;
                    d = 1'b1;
                end else begin
                    r   = x / y;
                    h   = x % y;
                    lat = W + 1;
                end
            end
`endif
            default: e = 1'b1;
        endcase
        return pk(r, h, (r == '0), v, d, e);
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            4:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- driver ----------------
    // One op from IDLE: accept, wait for the result, hold it for `hold`
    // cycles with out_ready low, then release and confirm the block drains.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [EW-1:0] expv, input int lat, input int hold,
                          input string tag);
        int cycles;
        int rdy_busy;
        logic [EW-1:0] e;
        @(negedge clk);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        cycles    = 0;
        while (!in_ready && cycles < TIMEOUT) begin
            @(negedge clk);
            cycles++;
        end
        chk({tag, "_accept"}, 64'(in_ready), 64'(1));
        exp_q.push_back(expv);
        lat_q.push_back(lat);
        @(negedge clk);
        in_valid = 1'b0;
        op       = 4'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
        cycles   = 1;
        rdy_busy = 0;
        while (!out_valid && cycles < TIMEOUT) begin
            if (in_ready) rdy_busy++;
            @(negedge clk);
            cycles++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_latency"}, 64'(cycles), 64'(lat_q.pop_front()));
        chk({tag, "_busy_ready"}, 64'(rdy_busy), 64'(0));
        e = exp_q.pop_front();
        chk({tag, "_fields"}, 64'(obs_fields()), 64'(e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_fields"}, 64'(obs_fields()), 64'(e));
            chk({tag, "_hold_hs"}, 64'({out_valid, in_ready}), 64'(2'b10));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_drain"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]   ops[10];
        logic [3:0]   o;
        logic [W-1:0] x, y;
        logic [EW-1:0] e;
        int           lat;
        int           seen;

        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL, OP_DIVU, 4'hF, 4'h3};
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;

        do_reset(3);
        chk("reset_fields", 64'(obs_fields()), 64'(pk('0, '0, 1'b0, 1'b0, 1'b0, 1'b0)));
        chk("reset_hs", 64'({out_valid, in_ready}), 64'(2'b01));
        chk("reset_state", 64'(dbg_state), 64'(IDLE));

        run_op(OP_ADD, 16'h7FFF, 16'h0001, pk(16'h8000, '0, 1'b0, 1'b1, 1'b0, 1'b0), 1, 0, "add_ovf");

        // SUB then SLT back-to-back, one accept per cycle.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = OP_SUB;
        a         = 16'h0005;
        b         = 16'h0005;
        exp_q.push_back(pk('0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        chk("b2b_ready0", 64'(in_ready), 64'(1));
        @(negedge clk);
        chk("b2b_sub", 64'(obs_fields()), 64'(exp_q.pop_front()));
        chk("b2b_hs0", 64'({out_valid, in_ready}), 64'(2'b11));
        op = OP_SLT;
        a  = 16'hFFFF;
        b  = 16'h0001;
        exp_q.push_back(pk(16'h0001, '0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk("b2b_slt", 64'(obs_fields()), 64'(exp_q.pop_front()));
        chk("b2b_hs1", 64'({out_valid, in_ready}), 64'(2'b11));
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drain", 64'(out_valid), 64'(0));

        // MUL with a three-cycle stall on the result.
        run_op(OP_MUL, 16'h0123, 16'h0456, pk(16'hEDC2, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0),
               W + 1, 3, "mul_hold");

`ifdef ALU_MC_DIV_EN
        run_op(OP_DIVU, 16'd100, 16'd7, pk(16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0),
               W + 1, 0, "divu");
        run_op(OP_DIVU, 16'd5, 16'd0, pk(16'hFFFF, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0),
               1, 0, "divu_dz");
`else
        run_op(OP_DIVU, 16'd100, 16'd7, pk('0, '0, 1'b1, 1'b0, 1'b0, 1'b1), 1, 0, "divu_illegal");
        run_op(OP_DIVU, 16'd5, 16'd0, pk('0, '0, 1'b1, 1'b0, 1'b0, 1'b1), 1, 0, "divu_dz_illegal");
`endif
        run_op(4'b1111, 16'h1234, 16'h5678, pk('0, '0, 1'b1, 1'b0, 1'b0, 1'b1), 1, 0, "op_1111");

        // Reset in the middle of an iterative op.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
`ifdef ALU_MC_DIV_EN
        op        = OP_DIVU;
`else
        op        = OP_MUL;
`endif
        a         = 16'h1234;
        b         = 16'h0011;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_busy", 64'(dbg_state), 64'(BUSY));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", 64'(dbg_state), 64'(IDLE));
        chk("midrst_hs", 64'({out_valid, in_ready}), 64'(2'b01));
        chk("midrst_fields", 64'(obs_fields()), 64'(pk('0, '0, 1'b0, 1'b0, 1'b0, 1'b0)));
        seen = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_valid", 64'(seen), 64'(0));

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 9)];
            x = pick_operand();
            y = pick_operand();
            e = ref_model(o, x, y, lat);
            run_op(o, x, y, e, lat, $urandom_range(0, 2), $sformatf("rnd%0d_op%0h", i, o));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
